// File: rtl/instr_fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared types and sizing helpers for the instruction fetch sequencer.
//   fetch_state_t   : sequencer states IDLE / FETCH / VALID
//   BYTES_PER_WORD  : bytes in a default 32-bit instruction word
//   BEAT_W          : beat-counter width for the default word size
//   beat_width()    : beat-counter width for an arbitrary byte count
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID
    } fetch_state_t;

    localparam int DEFAULT_BITS_DATA = 32;
    localparam int BYTES_PER_WORD    = DEFAULT_BITS_DATA / 8;
    localparam int BEAT_W            = $clog2(BYTES_PER_WORD);

    // Keep the counter at least one bit wide even for a single-byte word.
    function automatic int beat_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_sequencer_if
// Bundles the core-side fetch handshake and the ROM byte port.
//   fetch_req/fetch_pc/flush/instr_ack : requests and acknowledges from the core
//   fetch_busy/instr_valid/instr/fetch_err : sequencer status and result
//   mem_en/mem_addr : ROM byte read strobe and address
//   mem_rd          : ROM byte data, combinational from mem_addr
// Modports:
//   slave  : the sequencer's view
//   master : the environment (core plus ROM) driving the sequencer
// -----------------------------------------------------------------------------
interface instr_fetch_sequencer_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 7
);
    logic                 fetch_req;
    logic [BITS_ADDR-1:0] fetch_pc;
    logic                 flush;
    logic                 fetch_busy;
    logic                 instr_valid;
    logic [BITS_DATA-1:0] instr;
    logic                 instr_ack;
    logic                 fetch_err;
    logic                 mem_en;
    logic [BITS_ADDR-1:0] mem_addr;
    logic [7:0]           mem_rd;

    modport slave (
        input  fetch_req, fetch_pc, flush, instr_ack, mem_rd,
        output fetch_busy, instr_valid, instr, fetch_err, mem_en, mem_addr
    );

    modport master (
        output fetch_req, fetch_pc, flush, instr_ack, mem_rd,
        input  fetch_busy, instr_valid, instr, fetch_err, mem_en, mem_addr
    );
endinterface

// File: rtl/instr_fetch_sequencer_assembler.sv
// -----------------------------------------------------------------------------
// byte_word_assembler
// Collects ROM bytes MSB-first into an instruction word.
//   clk, reset  : clock and asynchronous active-high reset
//   clear       : restart the beat count and drop any partial bytes
//   shift       : take byte_in as the next byte and advance the beat count
//   load        : capture the assembled word (held bytes plus byte_in) into word
//   zero_word   : force the output word to zero
//   byte_in     : current ROM byte
//   beat        : index of the byte being taken this cycle
//   last_beat   : beat is the final byte of the word
//   word        : last completed word
// -----------------------------------------------------------------------------
module byte_word_assembler
    import instr_fetch_pkg::*;
#(
    parameter int BITS_DATA = DEFAULT_BITS_DATA
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             shift,
    input  logic                             load,
    input  logic                             zero_word,
    input  logic [7:0]                       byte_in,
    output logic [beat_width(BITS_DATA/8)-1:0] beat,
    output logic                             last_beat,
    output logic [BITS_DATA-1:0]             word
);
    localparam int NUM_BYTES = BITS_DATA / 8;
    localparam int CNT_W     = beat_width(NUM_BYTES);

    // Only the earlier bytes are held; the final byte joins straight from
    // byte_in so the word can be loaded on the same edge as the last beat.
    logic [BITS_DATA-9:0] shift_q;
    logic [BITS_DATA-1:0] assembled;

    assign assembled = {shift_q, byte_in};
    assign last_beat = (beat == CNT_W'(NUM_BYTES - 1));

    // Shift register and beat counter; clear wins over shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            beat    <= '0;
        end else if (clear) begin
            shift_q <= '0;
            beat    <= '0;
        end else if (shift) begin
            shift_q <= assembled[BITS_DATA-9:0];
            beat    <= beat + CNT_W'(1);
        end
    end

    // Output word register, only changed by a completed word or a forced zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
        end else if (zero_word) begin
            word <= '0;
        end else if (load) begin
            word <= assembled;
        end
    end
endmodule

// File: rtl/instr_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instr_fetch_sequencer
// Fetches a big-endian instruction word one ROM byte per cycle and hands it to
// the control unit with a valid/ack handshake; flush aborts or drops a word.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : instr_fetch_sequencer_if.slave (core handshake + ROM byte port)
// Optional feature macro FETCH_ALIGN_CHECK_EN: a request whose pc is not word
// aligned skips the ROM and returns instr=0 with fetch_err=1.
// -----------------------------------------------------------------------------
module instr_fetch_sequencer
    import instr_fetch_pkg::*;
#(
    parameter int BITS_DATA = DEFAULT_BITS_DATA,
    parameter int BITS_ADDR = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_fetch_sequencer_if.slave   bus
);
    localparam int NUM_BYTES = BITS_DATA / 8;
    localparam int CNT_W     = beat_width(NUM_BYTES);

    fetch_state_t         state;
    logic [BITS_ADDR-1:0] base;
    logic [BITS_ADDR-1:0] mem_addr_q;
    logic [BITS_ADDR-1:0] next_addr;
    logic                 mem_en_q;
    logic                 valid_q;
    logic                 err_q;
    logic [CNT_W-1:0]     beat;
    logic                 last_beat;
    logic [BITS_DATA-1:0] word;
    logic                 start_req;
    logic                 misaligned;
    logic                 asm_shift;

    // A new fetch starts from IDLE, or from VALID when the held word is
    // consumed in the same cycle (back-to-back); flush always blocks it.
    assign start_req = !bus.flush && bus.fetch_req &&
                       ((state == IDLE) || ((state == VALID) && bus.instr_ack));

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = start_req && (bus.fetch_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign asm_shift = (state == FETCH) && !bus.flush;

    // Address of the byte after the current beat; wraps at the top of the ROM.
    assign next_addr = base + BITS_ADDR'(beat) + BITS_ADDR'(1);

    byte_word_assembler #(
        .BITS_DATA (BITS_DATA)
    ) u_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.flush || start_req),
        .shift     (asm_shift),
        .load      (asm_shift && last_beat),
        .zero_word (misaligned),
        .byte_in   (bus.mem_rd),
        .beat      (beat),
        .last_beat (last_beat),
        .word      (word)
    );

    // Sequencer FSM. The start-of-fetch block sits after the case so a
    // back-to-back request overrides the return to IDLE on the same ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base       <= '0;
            mem_addr_q <= '0;
            mem_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else if (bus.flush) begin
            state    <= IDLE;
            mem_en_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (last_beat) begin
                        state    <= VALID;
                        valid_q  <= 1'b1;
                        mem_en_q <= 1'b0;
                    end else begin
                        mem_addr_q <= next_addr;
                    end
                end
                VALID: begin
                    if (bus.instr_ack) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (start_req) begin
                if (misaligned) begin
                    state    <= VALID;
                    valid_q  <= 1'b1;
                    err_q    <= 1'b1;
                    mem_en_q <= 1'b0;
                end else begin
                    state      <= FETCH;
                    base       <= bus.fetch_pc;
                    mem_addr_q <= bus.fetch_pc;
                    mem_en_q   <= 1'b1;
                end
            end
        end
    end

    // Busy while fetching, and while a word is held unless it is being
    // consumed together with a fresh request.
    assign bus.fetch_busy  = (state == FETCH) ||
                             ((state == VALID) && !(bus.instr_ack && bus.fetch_req));
    assign bus.instr_valid = valid_q;
    assign bus.instr       = word;
    assign bus.fetch_err   = err_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_sequencer
// Directed bench for instr_fetch_sequencer with a ROM model and a scoreboard:
// expected words are queued when a fetch is issued and popped by a monitor
// whenever the DUT hands a word over (instr_valid && instr_ack).
// -----------------------------------------------------------------------------
module tb_instr_fetch_sequencer;
    import instr_fetch_pkg::*;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [7:0] rom [0:127];

    instr_fetch_sequencer_if #(.BITS_DATA(32), .BITS_ADDR(7)) bus ();

    instr_fetch_sequencer #(
        .BITS_DATA (32),
        .BITS_ADDR (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational ROM byte port.
    assign bus.mem_rd = rom[bus.mem_addr];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [6:0] pc, input logic ack, input logic fl);
        bus.fetch_req = req;
        bus.fetch_pc  = pc;
        bus.instr_ack = ack;
        bus.flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handed-over word is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.instr_valid && bus.instr_ack) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_word", bus.instr, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_instr", bus.instr, e.word);
                checkOutput("sb_err", {31'd0, bus.fetch_err}, {31'd0, e.err});
            end
        end
    end

    // Full fetch: issue, check each beat address, optionally hold, then ack.
    task automatic runFetch(input logic [6:0] pc, input logic [31:0] expWord,
                            input int hold, input bit consume);
        sb.push_back('{word: expWord, err: 1'b0});
        applyStimulus(1'b1, pc, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("beat_mem_en", {31'd0, bus.mem_en}, 32'd1);
            checkOutput("beat_mem_addr", {25'd0, bus.mem_addr}, {25'd0, 7'(pc + i)});
            checkOutput("beat_busy", {31'd0, bus.fetch_busy}, 32'd1);
            tick();
        end
        checkOutput("word_valid", {31'd0, bus.instr_valid}, 32'd1);
        checkOutput("word_mem_en", {31'd0, bus.mem_en}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("hold_instr", bus.instr, expWord);
            checkOutput("hold_mem_en", {31'd0, bus.mem_en}, 32'd0);
            checkOutput("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
        end
        if (consume) begin
            applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
            tick();
            applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
            checkOutput("valid_after_ack", {31'd0, bus.instr_valid}, 32'd0);
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'(i * 3 + 1);
        rom[0]  = 8'h12; rom[1]  = 8'h34; rom[2]  = 8'h56; rom[3]  = 8'h78;
        rom[4]  = 8'h9A; rom[5]  = 8'hBC; rom[6]  = 8'hDE; rom[7]  = 8'hF0;
        rom[8]  = 8'h11; rom[9]  = 8'h22; rom[10] = 8'h33; rom[11] = 8'h44;
        rom[126] = 8'hAA; rom[127] = 8'hBB;

        reset = 1'b1;
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        tick();
        checkOutput("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("rst_instr", bus.instr, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.fetch_busy}, 32'd0);
        checkOutput("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        checkOutput("rst_mem_addr", {25'd0, bus.mem_addr}, 32'd0);
        checkOutput("rst_err", {31'd0, bus.fetch_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic fetch with a long hold, then back-to-back into pc=4.
        runFetch(7'h00, 32'h1234_5678, 10, 1'b0);
        sb.push_back('{word: 32'h9ABC_DEF0, err: 1'b0});
        applyStimulus(1'b1, 7'h04, 1'b1, 1'b0);
        #1;
        checkOutput("b2b_busy", {31'd0, bus.fetch_busy}, 32'd0);
        tick();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        checkOutput("b2b_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("b2b_mem_en", {31'd0, bus.mem_en}, 32'd1);
        checkOutput("b2b_addr0", {25'd0, bus.mem_addr}, 32'h04);
        for (int i = 1; i < 4; i++) begin
            tick();
            checkOutput("b2b_addr", {25'd0, bus.mem_addr}, 32'(4 + i));
        end
        tick();
        checkOutput("b2b_word_valid", {31'd0, bus.instr_valid}, 32'd1);
        applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);

        // Wrap at the top of the ROM: 7E,7F,00,01.
        runFetch(7'h7E, 32'hAABB_1234, 0, 1'b1);

        // Flush at beat 2 discards the partial word.
        applyStimulus(1'b1, 7'h10, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        checkOutput("flush_mem_en", {31'd0, bus.mem_en}, 32'd0);
        checkOutput("flush_busy", {31'd0, bus.fetch_busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("flush_valid", {31'd0, bus.instr_valid}, 32'd0);
            tick();
        end
        runFetch(7'h08, 32'h1122_3344, 0, 1'b1);

        // Asynchronous reset in the middle of a fetch.
        applyStimulus(1'b1, 7'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("arst_instr", bus.instr, 32'd0);
        checkOutput("arst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        checkOutput("arst_mem_addr", {25'd0, bus.mem_addr}, 32'd0);
        checkOutput("arst_busy", {31'd0, bus.fetch_busy}, 32'd0);
        checkOutput("arst_err", {31'd0, bus.fetch_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        checkOutput("post_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("post_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);

        // Unaligned request.
`ifdef FETCH_ALIGN_CHECK_EN
        sb.push_back('{word: 32'h0000_0000, err: 1'b1});
        applyStimulus(1'b1, 7'h02, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        checkOutput("align_mem_en", {31'd0, bus.mem_en}, 32'd0);
        checkOutput("align_valid", {31'd0, bus.instr_valid}, 32'd1);
        checkOutput("align_err", {31'd0, bus.fetch_err}, 32'd1);
        checkOutput("align_instr", bus.instr, 32'd0);
        tick();
        checkOutput("align_mem_en_hold", {31'd0, bus.mem_en}, 32'd0);
        applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        checkOutput("align_err_clr", {31'd0, bus.fetch_err}, 32'd0);
        checkOutput("align_valid_clr", {31'd0, bus.instr_valid}, 32'd0);
`else
        runFetch(7'h02, 32'h5678_9ABC, 0, 1'b1);
        checkOutput("noalign_err", {31'd0, bus.fetch_err}, 32'd0);
`endif

        tick();
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
